qsys_timer_irq_servicer: RTL and testbench



---
 rtl/qsys_timer_svc_pkg.sv | 29 ++
 rtl/qsys_avm_cmd_port.sv | 63 ++++++
 rtl/qsys_timer_irq_servicer.sv | 198 +++++++++++++++++++
 tb/tb_qsys_timer_irq_servicer.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qsys_timer_svc_pkg.sv
// Shared definitions for the interval-timer servicer.
// Contents: FSM state enum, timer register word addresses, control word.
// Build option: TIMER_SVC_PERIOD_WR_EN adds the PER_L/PER_H period-load states.
package qsys_timer_svc_pkg;

    typedef enum logic [3:0] {
        IDLE,
        EN_WR,
        WAIT_IRQ,
        CLR_WR,
        RD_CMD,
        RD_WAIT,
        DIS_WR
`ifdef TIMER_SVC_PERIOD_WR_EN
        , PER_L
        , PER_H
`endif
    } svc_state_t;

    localparam logic [2:0] TMR_STATUS   = 3'd0;
    localparam logic [2:0] TMR_CONTROL  = 3'd1;
    localparam logic [2:0] TMR_PERIOD_L = 3'd2;
    localparam logic [2:0] TMR_PERIOD_H = 3'd3;

    localparam logic [15:0] CTRL_ITO = 16'h0001;
    localparam logic [15:0] CTRL_OFF = 16'h0000;
    localparam logic [15:0] STAT_CLR = 16'h0000;

endpackage

// File: rtl/qsys_avm_cmd_port.sv
// Registered Avalon-MM command port for the timer servicer.
// A command is loaded when start is high and no command is outstanding, held
// while avm_waitrequest is high, and retired on the first cycle it is sampled
// low (done). Reads then start a READ_LATENCY down-counter; rdvalid marks the
// cycle whose closing edge sees valid avm_readdata.
// Ports:
//   clk, reset_n               clock, async active-low reset
//   start, wr, addr, wdata     command request from the FSM (wr = 1 for write)
//   avm_waitrequest            slave stall
//   avm_address, avm_chipselect, avm_write_n, avm_writedata   bus command
//   done                       command accepted this cycle
//   rdvalid                    avm_readdata valid this cycle
module qsys_avm_cmd_port #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        wr,
    input  logic [2:0]  addr,
    input  logic [15:0] wdata,
    input  logic        avm_waitrequest,
    output logic [2:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [15:0] avm_writedata,
    output logic        done,
    output logic        rdvalid
);

    logic [2:0] lat_cnt;

    assign done    = avm_chipselect & ~avm_waitrequest;
    assign rdvalid = (lat_cnt == 3'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avm_address    <= 3'd0;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_writedata  <= 16'h0000;
            lat_cnt        <= 3'd0;
        end else begin
            if (lat_cnt != 3'd0) begin
                lat_cnt <= lat_cnt - 3'd1;
            end
            if (done) begin
                avm_chipselect <= 1'b0;
                avm_write_n    <= 1'b1;
                // Read accepted: the data lands READ_LATENCY edges from now.
                if (avm_write_n) begin
                    lat_cnt <= 3'(READ_LATENCY);
                end
            end else if (!avm_chipselect && start) begin
                avm_chipselect <= 1'b1;
                avm_write_n    <= ~wr;
                avm_address    <= addr;
                avm_writedata  <= wdata;
            end
        end
    end

endmodule

// File: rtl/qsys_timer_irq_servicer.sv
// Autonomous interval-timer interrupt servicer (Avalon-MM initiator).
// Enables the timer IRQ, waits for irq_in, clears the timeout flag, reads
// status back to confirm the clear, and emits a tick pulse and tick count.
// Build option: TIMER_SVC_PERIOD_WR_EN also loads PERIOD into the timer
// period registers before enabling, forcing a counter reload.
// Ports:
//   clk, reset_n         clock, async active-low reset
//   enable               1 = service timer, 0 = disable IRQ and idle
//   irq_in               timer interrupt level
//   avm_*                Avalon-MM initiator to the timer slave
//   tick, tick_count     one-cycle pulse per serviced timeout, wrapping count
//   busy                 high outside IDLE and WAIT_IRQ
//   err                  sticky: timeout flag would not stay cleared
//
// state    | meaning
// IDLE     | timer IRQ disabled, waiting for enable
// PER_L    | write PERIOD[15:0] to period_l (option only)
// PER_H    | write PERIOD[31:16] to period_h (option only)
// EN_WR    | write ITO to control
// WAIT_IRQ | armed; leave on irq_in or enable low
// CLR_WR   | write 0 to status to clear timeout
// RD_CMD   | issue status read
// RD_WAIT  | wait for read data, check timeout bit
// DIS_WR   | write 0 to control, then idle
module qsys_timer_irq_servicer #(
    parameter int READ_LATENCY = 1,
    parameter int TICK_W       = 32,
    parameter int MAX_RETRY    = 3
`ifdef TIMER_SVC_PERIOD_WR_EN
    , parameter logic [31:0] PERIOD = 32'h000F423F
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              irq_in,
    output logic [2:0]        avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [15:0]       avm_writedata,
    input  logic [15:0]       avm_readdata,
    input  logic              avm_waitrequest,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic              busy,
    output logic              err
);

    import qsys_timer_svc_pkg::*;

    localparam int RETRY_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

    svc_state_t         state, state_nxt;
    logic               cmd_start, cmd_wr, cmd_done, cmd_rdvalid;
    logic [2:0]         cmd_addr;
    logic [15:0]        cmd_wdata;
    logic               tick_set, retry_inc, retry_clr, err_set;
    logic [RETRY_W-1:0] retry_cnt;
    logic               rd_unused;

    // Only the timeout bit of status matters here.
    assign rd_unused = ^avm_readdata[15:1];

    qsys_avm_cmd_port #(
        .READ_LATENCY (READ_LATENCY)
    ) u_cmd_port (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (cmd_start),
        .wr              (cmd_wr),
        .addr            (cmd_addr),
        .wdata           (cmd_wdata),
        .avm_waitrequest (avm_waitrequest),
        .avm_address     (avm_address),
        .avm_chipselect  (avm_chipselect),
        .avm_write_n     (avm_write_n),
        .avm_writedata   (avm_writedata),
        .done            (cmd_done),
        .rdvalid         (cmd_rdvalid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Command states hold cmd_start high for their whole duration; the port
    // ignores it while a command is outstanding, so each state issues once.
    always_comb begin
        state_nxt = state;
        cmd_start = 1'b0;
        cmd_wr    = 1'b1;
        cmd_addr  = TMR_STATUS;
        cmd_wdata = 16'h0000;
        tick_set  = 1'b0;
        retry_inc = 1'b0;
        retry_clr = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
`ifdef TIMER_SVC_PERIOD_WR_EN
                    state_nxt = PER_L;
`else
                    state_nxt = EN_WR;
`endif
                end
            end
`ifdef TIMER_SVC_PERIOD_WR_EN
            PER_L: begin
                cmd_start = 1'b1;
                cmd_addr  = TMR_PERIOD_L;
                cmd_wdata = PERIOD[15:0];
                if (cmd_done) state_nxt = PER_H;
            end
            PER_H: begin
                cmd_start = 1'b1;
                cmd_addr  = TMR_PERIOD_H;
                cmd_wdata = PERIOD[31:16];
                if (cmd_done) state_nxt = EN_WR;
            end
`endif
            EN_WR: begin
                cmd_start = 1'b1;
                cmd_addr  = TMR_CONTROL;
                cmd_wdata = CTRL_ITO;
                if (cmd_done) state_nxt = WAIT_IRQ;
            end
            WAIT_IRQ: begin
                if (!enable) begin
                    state_nxt = DIS_WR;
                end else if (irq_in) begin
                    state_nxt = CLR_WR;
                end
            end
            CLR_WR: begin
                cmd_start = 1'b1;
                cmd_addr  = TMR_STATUS;
                cmd_wdata = STAT_CLR;
                if (cmd_done) state_nxt = RD_CMD;
            end
            RD_CMD: begin
                cmd_start = 1'b1;
                cmd_wr    = 1'b0;
                cmd_addr  = TMR_STATUS;
                if (cmd_done) state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                if (cmd_rdvalid) begin
                    tick_set = 1'b1;
                    if (!avm_readdata[0]) begin
                        retry_clr = 1'b1;
                        state_nxt = WAIT_IRQ;
                    end else if (retry_cnt == RETRY_W'(MAX_RETRY - 1)) begin
                        err_set   = 1'b1;
                        retry_clr = 1'b1;
                        state_nxt = WAIT_IRQ;
                    end else begin
                        // A fresh timeout slipped in between clear and read.
                        retry_inc = 1'b1;
                        state_nxt = CLR_WR;
                    end
                end
            end
            DIS_WR: begin
                cmd_start = 1'b1;
                cmd_addr  = TMR_CONTROL;
                cmd_wdata = CTRL_OFF;
                if (cmd_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick       <= 1'b0;
            tick_count <= '0;
            retry_cnt  <= '0;
            err        <= 1'b0;
        end else begin
            tick <= tick_set;
            if (tick_set) tick_count <= tick_count + 1'b1;
            if (retry_clr) begin
                retry_cnt <= '0;
            end else if (retry_inc) begin
                retry_cnt <= retry_cnt + 1'b1;
            end
            if (err_set) err <= 1'b1;
        end
    end

    assign busy = (state != IDLE) && (state != WAIT_IRQ);

endmodule

// File: tb/tb_qsys_timer_irq_servicer.sv
module tb_qsys_timer_irq_servicer;

    localparam int RL   = 3;
    localparam int MAXR = 3;

    typedef struct packed {
        logic        wr;
        logic [2:0]  addr;
        logic [15:0] data;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        irq_in;
    logic [2:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [15:0] avm_writedata;
    logic [15:0] avm_readdata = 16'hFFFF;
    logic        avm_waitrequest = 1'b0;
    logic        tick;
    logic [31:0] tick_count;
    logic        busy;
    logic        err;

    int n_assert = 0;
    int n_fail   = 0;

    // slave model state
    txn_t        log_q[$];
    logic [15:0] resp_q[$];
    logic [15:0] rd_resp;
    int          rd_cnt      = 0;
    int          stall_left  = 0;
    int          stall_seen  = 0;
    bit          stalling    = 0;
    bit          held_bad    = 0;
    txn_t        snap;
    int          tick_hi     = 0;

    // reference model state
    txn_t        exp_q[$];
    logic [15:0] m_resp[$];
    int          m_ticks = 0;
    bit          m_err   = 0;

    qsys_timer_irq_servicer #(
        .READ_LATENCY (RL),
        .TICK_W       (32),
        .MAX_RETRY    (MAXR)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .irq_in          (irq_in),
        .avm_address     (avm_address),
        .avm_chipselect  (avm_chipselect),
        .avm_write_n     (avm_write_n),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .tick            (tick),
        .tick_count      (tick_count),
        .busy            (busy),
        .err             (err)
    );

    always #5 clk = ~clk;

    // Timer slave: inputs change on the falling edge, sampled by the DUT on
    // the rising edge. Read data is valid only for the one rising edge that is
    // RL edges after acceptance; every other cycle shows 0xFFFF (bit0 set).
    always @(negedge clk) begin
        txn_t cur;
        cur.wr   = !avm_write_n;
        cur.addr = avm_address;
        cur.data = avm_write_n ? 16'h0000 : avm_writedata;
        avm_readdata = 16'hFFFF;
        if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) avm_readdata = rd_resp;
        end
        if (tick) tick_hi++;
        if (avm_chipselect) begin
            if (stall_left > 0 && !avm_write_n && avm_address == 3'd0) begin
                if (!stalling) begin
                    snap     = cur;
                    stalling = 1;
                end else if (cur != snap) begin
                    held_bad = 1;
                end
                avm_waitrequest = 1'b1;
                stall_left--;
                stall_seen++;
            end else begin
                if (stalling && cur != snap) held_bad = 1;
                stalling        = 0;
                avm_waitrequest = 1'b0;
                log_q.push_back(cur);
                if (avm_write_n) begin
                    rd_resp = (resp_q.size() > 0) ? resp_q.pop_front() : 16'h0000;
                    rd_cnt  = RL;
                end
            end
        end else begin
            avm_waitrequest = 1'b0;
        end
    end

    function automatic string fmt(input txn_t q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%s%0d:%h ", q[i].wr ? "W" : "R", q[i].addr, q[i].data)};
        return s;
    endfunction

    function automatic txn_t mk(input logic w, input logic [2:0] a, input logic [15:0] d);
        txn_t t;
        t.wr = w; t.addr = a; t.data = d;
        return t;
    endfunction

    // Model: the accesses that bring the timer from IDLE to armed.
    task automatic model_enable();
`ifdef TIMER_SVC_PERIOD_WR_EN
        exp_q.push_back(mk(1'b1, 3'd2, 16'h423F));
        exp_q.push_back(mk(1'b1, 3'd3, 16'h000F));
`endif
        exp_q.push_back(mk(1'b1, 3'd1, 16'h0001));
    endtask

    // Model: one serviced interrupt, consuming status readbacks from m_resp.
    task automatic model_irq();
        int retries = 0;
        logic [15:0] v;
        while (1) begin
            exp_q.push_back(mk(1'b1, 3'd0, 16'h0000));
            exp_q.push_back(mk(1'b0, 3'd0, 16'h0000));
            v = m_resp.pop_front();
            m_ticks++;
            if (!v[0]) break;
            retries++;
            if (retries == MAXR) begin
                m_err = 1;
                break;
            end
        end
    endtask

    task automatic clear_slave();
        log_q.delete(); resp_q.delete(); exp_q.delete(); m_resp.delete();
        rd_cnt = 0; stall_left = 0; stall_seen = 0; stalling = 0; held_bad = 0;
        avm_waitrequest = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        enable  = 1'b0;
        irq_in  = 1'b0;
        clear_slave();
        m_ticks = 0;
        m_err   = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic settle();
        int n = 0;
        repeat (3) @(negedge clk);
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            n_assert++; n_fail++;
            $display("FAIL settle_timeout: busy=%0b after %0d cycles, required 0", busy, n);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic fire_irq(input int hold);
        irq_in = 1'b1;
        repeat (hold) @(negedge clk);
        irq_in = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1; enable = 1'b0; irq_in = 1'b0;
        do_reset();
        #1;
        n_assert++;
        if ({avm_chipselect, avm_write_n, avm_address, avm_writedata} !== {1'b0, 1'b1, 3'd0, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset_bus: cs=%b wn=%b a=%0d d=%h, required 0 1 0 0000",
                     avm_chipselect, avm_write_n, avm_address, avm_writedata);
        end
        n_assert++;
        if ({tick, tick_count, busy, err} !== {1'b0, 32'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_status: tick=%b cnt=%0d busy=%b err=%b, required all 0", tick, tick_count, busy, err);
        end
    endtask

    task automatic test_enable();
        clear_slave();
        model_enable();
        enable = 1'b1;
        settle();
        n_assert++;
        if (fmt(log_q) != fmt(exp_q)) begin
            n_fail++;
            $display("FAIL enable_seq: got '%s' required '%s'", fmt(log_q), fmt(exp_q));
        end
        n_assert++;
        if (busy !== 1'b0 || tick_count !== 32'd0) begin
            n_fail++;
            $display("FAIL enable_idle: busy=%b cnt=%0d, required 0 0", busy, tick_count);
        end
    endtask

    task automatic run_irq(input logic [15:0] r[$], input int hold, input int stall, input string nm);
        int t0 = tick_hi;
        int c0 = m_ticks;
        clear_slave();
        foreach (r[i]) begin
            resp_q.push_back(r[i]);
            m_resp.push_back(r[i]);
        end
        stall_left = stall;
        model_irq();
        fire_irq(hold);
        settle();
        n_assert++;
        if (fmt(log_q) != fmt(exp_q)) begin
            n_fail++;
            $display("FAIL %s_seq: got '%s' required '%s'", nm, fmt(log_q), fmt(exp_q));
        end
        n_assert++;
        if (tick_count !== 32'(m_ticks)) begin
            n_fail++;
            $display("FAIL %s_count: tick_count=%0d required %0d", nm, tick_count, m_ticks);
        end
        n_assert++;
        if (tick_hi - t0 != m_ticks - c0) begin
            n_fail++;
            $display("FAIL %s_tick: tick high cycles=%0d required %0d", nm, tick_hi - t0, m_ticks - c0);
        end
        n_assert++;
        if (err !== m_err || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_err: err=%b busy=%b required err=%b busy=0", nm, err, busy, m_err);
        end
    endtask

    task automatic test_single_irq();
        run_irq('{16'h0002}, 5, 0, "single");
    endtask

    task automatic test_retry_once();
        run_irq('{16'h0001, 16'h0000}, 1, 0, "retry");
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            logic [15:0] r[$];
            for (int k = 0; k < MAXR; k++) begin
                logic [15:0] v;
                v    = 16'($urandom);
                v[0] = ($urandom_range(0, 2) == 0);
                r.push_back(v);
            end
            run_irq(r, $urandom_range(1, 5), $urandom_range(0, 3), $sformatf("rand%0d", it));
        end
    endtask

    task automatic test_stuck();
        run_irq('{16'hFFFF, 16'h0001, 16'h8001}, 2, 0, "stuck");
        n_assert++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL stuck_err: err=%b required 1", err);
        end
    endtask

    task automatic test_waitrequest();
        run_irq('{16'h0000}, 1, 4, "stall");
        n_assert++;
        if (held_bad !== 1'b0 || stall_seen != 4) begin
            n_fail++;
            $display("FAIL stall_hold: changed=%b stalled_cycles=%0d, required 0 4", held_bad, stall_seen);
        end
    endtask

    task automatic test_disable();
        clear_slave();
        exp_q.push_back(mk(1'b1, 3'd1, 16'h0000));
        enable = 1'b0;
        settle();
        n_assert++;
        if (fmt(log_q) != fmt(exp_q) || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL disable_seq: got '%s' busy=%b required '%s' busy=0", fmt(log_q), busy, fmt(exp_q));
        end
        clear_slave();
        model_enable();
        enable = 1'b1;
        settle();
        n_assert++;
        if (fmt(log_q) != fmt(exp_q)) begin
            n_fail++;
            $display("FAIL reenable_seq: got '%s' required '%s'", fmt(log_q), fmt(exp_q));
        end
    endtask

    task automatic test_disable_mid();
        clear_slave();
        resp_q.push_back(16'h0000);
        m_resp.push_back(16'h0000);
        model_irq();
        exp_q.push_back(mk(1'b1, 3'd1, 16'h0000));
        fire_irq(1);
        n_assert++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy: busy=%b required 1", busy);
        end
        enable = 1'b0;
        settle();
        n_assert++;
        if (fmt(log_q) != fmt(exp_q) || tick_count !== 32'(m_ticks)) begin
            n_fail++;
            $display("FAIL mid_disable: got '%s' cnt=%0d required '%s' cnt=%0d",
                     fmt(log_q), tick_count, fmt(exp_q), m_ticks);
        end
        clear_slave();
        model_enable();
        enable = 1'b1;
        settle();
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clear_slave();
        stall_left = 20;
        fire_irq(1);
        while (stall_seen < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_assert++;
        if (stall_seen < 2 || avm_chipselect !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_setup: stalled=%0d cs=%b, required >=2 1", stall_seen, avm_chipselect);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_assert++;
        if ({avm_chipselect, avm_write_n, avm_address, avm_writedata, tick, tick_count, busy, err}
                !== {1'b0, 1'b1, 3'd0, 16'h0000, 1'b0, 32'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rstmid_out: cs=%b wn=%b a=%0d d=%h tick=%b cnt=%0d busy=%b err=%b, required reset values",
                     avm_chipselect, avm_write_n, avm_address, avm_writedata, tick, tick_count, busy, err);
        end
        clear_slave();
        m_ticks = 0;
        m_err   = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_enable();
        settle();
        n_assert++;
        if (fmt(log_q) != fmt(exp_q)) begin
            n_fail++;
            $display("FAIL rstmid_restart: got '%s' required '%s'", fmt(log_q), fmt(exp_q));
        end
    endtask

    initial begin
        test_reset();
        test_enable();
        test_single_irq();
        test_retry_once();
        test_random();
        test_waitrequest();
        test_stuck();
        test_disable();
        test_disable_mid();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
